icache: RTL

- Instruction cache that answers the fetch unit's one-word request/success handshake.
- Direct-mapped, one 32-bit instruction per line.
- Hits return in one cycle. Misses issue a word read to the memory controller, fill the line, then answer.
- Sits between the fetch unit and the memory controller. Handles jump-flush so stale misses never answer the fetch unit.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_array.sv | 44 ++++
 rtl/icache.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: default geometry,
// derived index/tag widths and controller state encodings.
package icache_pkg;

    localparam int unsigned ICACHE_LINES  = 256;
    localparam int unsigned ICACHE_ADDR_W = 32;
    localparam int unsigned ICACHE_IDX_W  = $clog2(ICACHE_LINES);
    localparam int unsigned ICACHE_TAG_W  = ICACHE_ADDR_W - ICACHE_IDX_W - 2;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] COOL     = 2'd2;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// one synchronous write port. Only the valid bits are reset.
module icache_array #(
    parameter int unsigned LINES  = 256,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and memory controller.
// Define ICACHE_STAT_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES  = ICACHE_LINES,
    parameter int unsigned ADDR_W = ICACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IC_S,
    input  logic [ADDR_W-1:0] IC_pc,
    output logic              IC_success,
    output logic [31:0]       IC_value,
    input  logic              ROB_Jump_S,
    output logic              MC_S,
    output logic [ADDR_W-1:0] MC_addr,
    input  logic              MC_success,
    input  logic [31:0]       MC_value
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = ADDR_W - IdxW - 2;

    logic [1:0]        state_q, state_d;
    logic              ic_success_q, ic_success_d;
    logic [31:0]       ic_value_q, ic_value_d;
    logic              mc_s_q, mc_s_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-3:0] miss_pc_q, miss_pc_d;

    logic              rd_valid;
    logic [TagW-1:0]   rd_tag;
    logic [31:0]       rd_data;
    logic              lookup_hit;
    logic              req_take;
    logic              fill_we;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^IC_pc[1:0];

    icache_array #(
        .LINES  (LINES),
        .IDX_W  (IdxW),
        .TAG_W  (TagW),
        .DATA_W (32)
    ) u_array (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_idx_i   (IC_pc[IdxW+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (miss_pc_q[IdxW-1:0]),
        .wr_tag_i   (miss_pc_q[ADDR_W-3:IdxW]),
        .wr_data_i  (MC_value)
    );

    assign lookup_hit = rd_valid && (rd_tag == IC_pc[ADDR_W-1:IdxW+2]);
    assign req_take   = rdy && !ROB_Jump_S && (state_q == IDLE) && IC_S && !ic_success_q;
    // The fill is never cancelled: flush and rdy=0 only suppress the response.
    assign fill_we    = (state_q == WAIT_MEM) && MC_success;

    always_comb begin
        state_d      = state_q;
        ic_success_d = 1'b0;
        ic_value_d   = ic_value_q;
        mc_s_d       = mc_s_q;
        mc_addr_d    = mc_addr_q;
        abort_d      = abort_q;
        miss_pc_d    = miss_pc_q;

        if (fill_we) begin
            mc_s_d = 1'b0;
        end

        if (!rdy || ROB_Jump_S) begin
            if (state_q == WAIT_MEM) begin
                if (MC_success) begin
                    abort_d = 1'b0;
                    state_d = IDLE;
                end else if (ROB_Jump_S) begin
                    abort_d = 1'b1;
                end
            end else if (rdy) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        if (lookup_hit) begin
                            ic_success_d = 1'b1;
                            ic_value_d   = rd_data;
                            state_d      = COOL;
                        end else begin
                            miss_pc_d = IC_pc[ADDR_W-1:2];
                            mc_s_d    = 1'b1;
                            mc_addr_d = {IC_pc[ADDR_W-1:2], 2'b00};
                            state_d   = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (MC_success) begin
                        if (!abort_q) begin
                            ic_success_d = 1'b1;
                            ic_value_d   = MC_value;
                            state_d      = COOL;
                        end else begin
                            abort_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ic_success_q <= 1'b0;
            ic_value_q   <= '0;
            mc_s_q       <= 1'b0;
            mc_addr_q    <= '0;
            abort_q      <= 1'b0;
            miss_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            ic_success_q <= ic_success_d;
            ic_value_q   <= ic_value_d;
            mc_s_q       <= mc_s_d;
            mc_addr_q    <= mc_addr_d;
            abort_q      <= abort_d;
            miss_pc_q    <= miss_pc_d;
        end
    end

    assign IC_success = ic_success_q;
    assign IC_value   = ic_value_q;
    assign MC_S       = mc_s_q;
    assign MC_addr    = mc_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (req_take && lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (req_take && !lookup_hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
